// File: rtl/alarm_beeper.sv
// Alarm beeper: turns a level alarm request into a fixed train of tone
// bursts on a piezo, with a level cancel that wins over everything else.
module alarm_beeper #(
    parameter int TONE_DIV   = 12500,
    parameter int BEEP_ON    = 12500000,
    parameter int BEEP_OFF   = 12500000,
    parameter int BEEP_COUNT = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    input  logic silence,
    output logic speaker,
    output logic active,
    output logic done
);

    localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int PW = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int BW = (BEEP_COUNT > 1) ? $clog2(BEEP_COUNT) : 1;

    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
    localparam logic [PW-1:0] ON_LAST   = PW'(BEEP_ON - 1);
    localparam logic [PW-1:0] OFF_LAST  = PW'(BEEP_OFF - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        TONE_ON,
        TONE_OFF,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] beep_q, beep_d;
    logic          tone_q, tone_d;
    logic          spk_q, spk_d;
    logic          done_q, done_d;

    always_comb begin
        state_d    = state_q;
        tone_cnt_d = tone_cnt_q;
        phase_d    = phase_q;
        beep_d     = beep_q;
        tone_d     = tone_q;
        done_d     = 1'b0;

        if (silence) begin
            state_d    = IDLE;
            tone_cnt_d = '0;
            phase_d    = '0;
            beep_d     = '0;
            tone_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_d    = TONE_ON;
                        tone_cnt_d = '0;
                        phase_d    = '0;
                        beep_d     = '0;
                        tone_d     = 1'b0;
                    end
                end
                TONE_ON: begin
                    if (tone_cnt_q == TONE_LAST) begin
                        tone_cnt_d = '0;
                        tone_d     = ~tone_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 1'b1;
                    end
                    if (phase_q == ON_LAST) begin
                        phase_d    = '0;
                        tone_cnt_d = '0;
                        tone_d     = 1'b0;
                        if (beep_q == BEEP_LAST) begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end else begin
                            state_d = TONE_OFF;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                TONE_OFF: begin
                    if (phase_q == OFF_LAST) begin
                        phase_d    = '0;
                        beep_d     = beep_q + 1'b1;
                        tone_cnt_d = '0;
                        tone_d     = 1'b0;
                        state_d    = TONE_ON;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                HOLD: begin
                    // Wait for the request to drop so one assertion gives one sequence.
                    if (!trigger) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign spk_d = (state_d == TONE_ON) & tone_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tone_cnt_q <= '0;
            phase_q    <= '0;
            beep_q     <= '0;
            tone_q     <= 1'b0;
            spk_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tone_cnt_q <= tone_cnt_d;
            phase_q    <= phase_d;
            beep_q     <= beep_d;
            tone_q     <= tone_d;
            spk_q      <= spk_d;
            done_q     <= done_d;
        end
    end

    assign speaker = spk_q;
    assign active  = (state_q == TONE_ON) || (state_q == TONE_OFF);
    assign done    = done_q;

endmodule

// File: tb/tb_alarm_beeper.sv
// Bench for alarm_beeper: two builds (3 beeps and 1 beep) share stimulus;
// a timing model feeds per-cycle expectations to a negedge monitor.
module tb_alarm_beeper;

    localparam int TD   = 2;
    localparam int BON  = 8;
    localparam int BOFF = 4;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b0;
    logic trig = 1'b0;
    logic sil = 1'b0;

    logic spk_a, act_a, done_a;
    logic spk_b, act_b, done_b;

    int total = 0;
    int bad = 0;

    logic [2:0] qa[$];
    logic [2:0] qb[$];

    int seq_t[2] = '{-1, -1};
    bit hold_s[2] = '{1'b0, 1'b0};

    alarm_beeper #(
        .TONE_DIV(TD), .BEEP_ON(BON), .BEEP_OFF(BOFF), .BEEP_COUNT(3)
    ) dut_a (
        .clk(clk), .reset(rst), .trigger(trig), .silence(sil),
        .speaker(spk_a), .active(act_a), .done(done_a)
    );

    alarm_beeper #(
        .TONE_DIV(TD), .BEEP_ON(BON), .BEEP_OFF(BOFF), .BEEP_COUNT(1)
    ) dut_b (
        .clk(clk), .reset(rst), .trigger(trig), .silence(sil),
        .speaker(spk_b), .active(act_b), .done(done_b)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Sequence position -> outputs, straight from the beep/gap/tone timing.
    function automatic logic [2:0] model_step(int k, bit r, bit tr, bit si);
        int nb;
        int len;
        int off;
        logic d;
        logic s;
        logic a;
        nb  = (k == 0) ? 3 : 1;
        len = nb * BON + (nb - 1) * BOFF;
        d = 1'b0;
        s = 1'b0;
        a = 1'b0;
        if (r || si) begin
            seq_t[k]  = -1;
            hold_s[k] = 1'b0;
        end else if (seq_t[k] >= 0) begin
            seq_t[k]++;
            if (seq_t[k] == len) begin
                seq_t[k]  = -1;
                hold_s[k] = 1'b1;
                d = 1'b1;
            end
        end else if (hold_s[k]) begin
            if (!tr) hold_s[k] = 1'b0;
        end else if (tr) begin
            seq_t[k] = 0;
        end
        if (seq_t[k] >= 0) begin
            a = 1'b1;
            off = seq_t[k] % (BON + BOFF);
            if (off < BON) s = ((off / TD) % 2) == 1;
        end
        return {s, a, d};
    endfunction

    always @(posedge clk) begin
        qa.push_back(model_step(0, rst, trig, sil));
        qb.push_back(model_step(1, rst, trig, sil));
    end

    task automatic cmp(string name, logic [2:0] got, logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got spk/act/done=%b required=%b",
                     name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0) cmp("dut_a", {spk_a, act_a, done_a}, qa.pop_front());
        if (qb.size() > 0) cmp("dut_b", {spk_b, act_b, done_b}, qb.pop_front());
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with no clock running.
        #2 rst = 1'b1;
        #1;
        cmp("rst_noclk_a", {spk_a, act_a, done_a}, 3'b000);
        cmp("rst_noclk_b", {spk_b, act_b, done_b}, 3'b000);
        clk_en = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Full sequence, then trigger held long, then re-armed.
        trig = 1'b1;
        tick(40);
        tick(100);
        trig = 1'b0;
        tick(1);
        trig = 1'b1;
        tick(40);
        trig = 1'b0;
        tick(3);

        // Silence during the second beep.
        trig = 1'b1;
        tick(15);
        sil = 1'b1;
        trig = 1'b0;
        tick(2);
        sil = 1'b0;
        tick(40);

        // Trigger and silence together.
        trig = 1'b1;
        sil = 1'b1;
        tick(20);
        sil = 1'b0;
        trig = 1'b0;
        tick(3);

        // Reset mid-sequence with the clock stopped; trigger stays high.
        trig = 1'b1;
        tick(14);
        cmp("pre_rst_active", {1'b0, act_a, 1'b0}, 3'b010);
        @(negedge clk);
        clk_en = 1'b0;
        #20 rst = 1'b1;
        #1;
        cmp("rst_mid_a", {spk_a, act_a, done_a}, 3'b000);
        cmp("rst_mid_b", {spk_b, act_b, done_b}, 3'b000);
        #4 clk_en = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(40);
        trig = 1'b0;
        tick(3);

        // Random trigger/silence traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) trig = ~trig;
            sil = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        sil = 1'b0;
        trig = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
